// File: rtl/keypad_loader.sv
// rtl/keypad_loader.sv - debounced 10-key keypad to BCD digit loader for the countdown timer
// Optional build macro: KEYPAD_LOADER_DIGIT_LIMIT_EN (suppress loads once three digits are entered)
module keypad_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [9:0] keys,
    input  logic       lock,
    output logic [3:0] data_out,
    output logic       loadn,
    output logic [1:0] digit_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        LOAD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // One extra bit so the increment can be compared without wrapping.
    localparam logic [CNT_W:0] DB_LIMIT = (CNT_W + 1)'(DEBOUNCE_CYCLES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [9:0]       cap, cap_n;
    logic [3:0]       data_n;
    logic             loadn_n;
    logic [1:0]       count_n;
    logic             busy_n;

    logic [CNT_W:0]   cnt_inc;
    logic             cnt_done;
    logic             key_valid;
    logic             load_en;

    // Binary index of the single set bit of a one-hot keypad pattern.
    function automatic logic [3:0] onehot_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign cnt_done  = (cnt_inc >= DB_LIMIT);
    assign key_valid = (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);

`ifdef KEYPAD_LOADER_DIGIT_LIMIT_EN
    // Keep the minutes digit safe: a fourth digit debounces but never shifts in.
    assign load_en = (digit_count != 2'd3);
`else
    assign load_en = 1'b1;
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        data_n  = data_out;
        loadn_n = 1'b1;
        count_n = digit_count;
        case (state)
            IDLE: begin
                if (!lock && key_valid) begin
                    state_n = PRESS_DB;
                    cap_n   = keys;
                    cnt_n   = CNT_W'(1);
                end
            end
            PRESS_DB: begin
                if (lock || (keys != cap)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_done) begin
                    state_n = LOAD;
                    cnt_n   = '0;
                    if (load_en) begin
                        loadn_n = 1'b0;
                        data_n  = onehot_index(cap);
                    end
                    if (digit_count != 2'd3) count_n = digit_count + 2'd1;
                end else begin
                    cnt_n = cnt_inc[CNT_W-1:0];
                end
            end
            LOAD: begin
                state_n = RELEASE_DB;
                cnt_n   = '0;
            end
            RELEASE_DB: begin
                if (keys == 10'd0) begin
                    if (cnt_done) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc[CNT_W-1:0];
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; clear drops everything to idle immediately.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= IDLE;
            cnt         <= '0;
            cap         <= '0;
            data_out    <= 4'd0;
            loadn       <= 1'b1;
            digit_count <= 2'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cap         <= cap_n;
            data_out    <= data_n;
            loadn       <= loadn_n;
            digit_count <= count_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_keypad_loader.sv
// tb/tb_keypad_loader.sv - directed self-checking bench for keypad_loader
module tb_keypad_loader;

    logic       clock;
    logic       clear;
    logic [9:0] keys;
    logic       lock;
    logic [3:0] data_out;
    logic       loadn;
    logic [1:0] digit_count;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int loads  = 0;
    int base   = 0;
    logic [3:0] last_ld = 4'd0;

    keypad_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .keys        (keys),
        .lock        (lock),
        .data_out    (data_out),
        .loadn       (loadn),
        .digit_count (digit_count),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record each load strobe and the digit presented with it.
    always @(negedge clock) begin
        if (clear === 1'b1 && loadn === 1'b0) begin
            loads   <= loads + 1;
            last_ld <= data_out;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [9:0] k, input int hold, input int rel);
        keys = k;
        step(hold);
        keys = 10'd0;
        step(rel);
    endtask

    initial begin
        clear = 1'b0;
        keys  = 10'd0;
        lock  = 1'b0;
        #12;
        check("rst_data", data_out, 0);
        check("rst_loadn", loadn, 1);
        check("rst_count", digit_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clock);
        #1;
        clear = 1'b1;
        step(2);

        // Key 5 held 10 cycles: strobe exactly 4 samples after first sample.
        keys = 10'd1 << 5;
        step(1);
        check("k5_busy", busy, 1);
        check("k5_loadn_e1", loadn, 1);
        step(2);
        check("k5_loadn_e3", loadn, 1);
        step(1);
        check("k5_loadn_e4", loadn, 0);
        check("k5_data", data_out, 5);
        check("k5_count", digit_count, 1);
        step(1);
        check("k5_loadn_end", loadn, 1);
        step(5);
        keys = 10'd0;
        step(3);
        check("k5_rel_busy", busy, 1);
        step(3);
        check("k5_idle", busy, 0);
        check("k5_loads", loads, 1);

        // Key 3 bounce for 2 cycles only.
        keys = 10'd1 << 3;
        step(1);
        check("k3_busy", busy, 1);
        step(1);
        keys = 10'd0;
        step(1);
        check("k3_idle", busy, 0);
        step(6);
        check("k3_loads", loads, 1);
        check("k3_count", digit_count, 1);

        // Two keys at once are ignored, then key 7 loads.
        keys = 10'b0000000110;
        step(20);
        check("dual_busy", busy, 0);
        check("dual_loads", loads, 1);
        keys = 10'd0;
        step(2);
        press(10'd1 << 7, 6, 6);
        check("k7_loads", loads, 2);
        check("k7_ld", last_ld, 7);
        check("k7_data", data_out, 7);
        check("k7_count", digit_count, 2);

        // Key 9 long hold, short release, re-press: only one load.
        keys = 10'd1 << 9;
        step(50);
        keys = 10'd0;
        step(2);
        keys = 10'd1 << 9;
        step(3);
        keys = 10'd0;
        step(3);
        check("k9_busy_rel3", busy, 1);
        step(1);
        check("k9_idle_rel4", busy, 0);
        step(6);
        check("k9_loads", loads, 3);
        check("k9_data", data_out, 9);
        check("k9_count", digit_count, 3);

        // Fresh reset, then digits 1, 2, 0, 4.
        clear = 1'b0;
        #1;
        check("rst2_count", digit_count, 0);
        check("rst2_data", data_out, 0);
        clear = 1'b1;
        step(2);
        base = loads;
        press(10'd1 << 1, 6, 6);
        check("seq1_data", data_out, 1);
        check("seq1_count", digit_count, 1);
        press(10'd1 << 2, 6, 6);
        check("seq2_data", data_out, 2);
        check("seq2_count", digit_count, 2);
        press(10'd1, 6, 6);
        check("seq0_data", data_out, 0);
        check("seq0_ld", last_ld, 0);
        check("seq0_count", digit_count, 3);
        press(10'd1 << 4, 6, 6);
`ifdef KEYPAD_LOADER_DIGIT_LIMIT_EN
        check("seq4_data", data_out, 0);
        check("seq4_loads", loads - base, 3);
`else
        check("seq4_data", data_out, 4);
        check("seq4_loads", loads - base, 4);
`endif
        check("seq4_count", digit_count, 3);

        // Lock rising during PRESS_DB aborts; key 6 held under lock never loads.
        base = loads;
        keys = 10'd1 << 6;
        step(2);
        check("lock_pdb_busy", busy, 1);
        lock = 1'b1;
        step(1);
        check("lock_abort", busy, 0);
        step(8);
        check("lock_busy", busy, 0);
        check("lock_loads", loads - base, 0);
        keys = 10'd0;
        step(1);
        lock = 1'b0;
        step(2);

        // Asynchronous clear in PRESS_DB.
        keys = 10'd1 << 2;
        step(2);
        check("clr_pdb_busy", busy, 1);
        #2;
        clear = 1'b0;
        #1;
        check("clr_pdb_busy0", busy, 0);
        check("clr_pdb_count", digit_count, 0);
        check("clr_pdb_loadn", loadn, 1);
        keys = 10'd0;
        #1;
        clear = 1'b1;
        step(2);

        // Asynchronous clear cuts a strobe in progress.
        keys = 10'd1 << 8;
        step(4);
        check("clr_ld_loadn0", loadn, 0);
        check("clr_ld_data8", data_out, 8);
        #2;
        clear = 1'b0;
        #1;
        check("clr_ld_loadn1", loadn, 1);
        check("clr_ld_data0", data_out, 0);
        check("clr_ld_busy", busy, 0);
        keys = 10'd0;
        #1;
        clear = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Upstream feeder of the microwave countdown timer.
- Converts a 10-key decimal keypad (keys 0-9, one line per key) into debounced BCD digits.
- For each accepted keypress, issues one load strobe, which shifts the digit into the timer's seconds-ones stage. Earlier digits move toward tens and minutes.
- Counts the digits entered. Ignores the keypad while the oven is cooking.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a press, and again to accept a release. Legal range 1..255.
- CNT_W, 8: width of the internal debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clock, input, 1: system clock; all state changes on the rising edge.
- clear, input, 1: asynchronous, active-low reset.
- keys, input, 10: keypad lines, active-high; bit i = digit i. Already synchronised.
- lock, input, 1: high while the timer is counting; keypad input is ignored.
- data_out, output, 4: BCD digit for the timer's data_in.
- loadn, output, 1: active-low load strobe to the timer.
- digit_count, output, 2: digits entered since reset, saturating at 3.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (clear=0, asynchronous), all immediate:
  - state=IDLE, data_out=4'd0, loadn=1, digit_count=0, busy=0, debounce counter=0, captured pattern=0.
- Valid pattern: keys has exactly one bit set. Zero bits or two or more bits is not valid.
- IDLE:
  - Move to PRESS_DB when lock=0 and keys is a valid pattern.
  - On that transition, capture keys into the captured pattern and set counter=1.
- PRESS_DB:
  - keys == captured pattern: counter increments.
  - When counter reaches DEBOUNCE_CYCLES and the pattern still matches, go to LOAD.
  - keys differs (including becoming invalid): go back to IDLE with counter=0. No load.
  - lock rising: go back to IDLE.
- LOAD, exactly one cycle:
  - loadn=0 for this cycle only.
  - data_out = binary index of the captured bit, registered on entry to LOAD, so it is valid in the same cycle loadn=0.
  - digit_count increments, saturating at 3.
  - Next state is RELEASE_DB with counter=0.
- data_out holds its value after LOAD until the next LOAD or a reset.
- RELEASE_DB:
  - keys==0: counter increments. keys!=0: counter resets to 0.
  - Go to IDLE when counter reaches DEBOUNCE_CYCLES.
  - Holding or re-pressing a key never produces a second load.
- Latency: a clean press first seen at cycle t gives loadn=0 at cycle t+DEBOUNCE_CYCLES.
- lock=1:
  - IDLE never leaves IDLE.
  - If lock goes high during LOAD, the load still completes. One-cycle strobes are never truncated.
- Reset mid-operation: asynchronous return to the reset values. A loadn=0 in progress ends immediately (loadn=1).
- loadn is registered and glitch-free. All outputs are registered.
- Digit 0 is a legal digit: data_out=0 with a load.

Optional Feature:
- Macro: KEYPAD_LOADER_DIGIT_LIMIT_EN.
- Defined: once digit_count==3, presses still debounce and pass through RELEASE_DB, but LOAD is replaced by a no-op cycle. loadn stays 1 and data_out is unchanged, so the timer never loses the minutes digit to overflow.
- Undefined: every accepted press loads. digit_count still saturates at 3, while the timer keeps shifting digits and the oldest digit falls off.

Test Plan:
- Reset, then press key 5 held 10 cycles with DEBOUNCE_CYCLES=4 -> one loadn=0 pulse, 4 cycles after first sample, with data_out=5; digit_count=1.
- Key 3 pulses high for 2 cycles only (bounce) -> no loadn pulse; state returns to IDLE; digit_count unchanged.
- keys=10'b0000000110 (keys 1 and 2) held 20 cycles -> no load. Then release and press key 7 -> a single load with data_out=7.
- Hold key 9 for 50 cycles, release for 2 cycles, press again for 3 cycles, then release for 10 cycles -> exactly one load with data_out=9, busy=1 until the release is debounced.
- Sequence 1, 2, 0, 4 -> four loads with data_out 1, 2, 0, 4 and digit_count reading 1, 2, 3, 3. With KEYPAD_LOADER_DIGIT_LIMIT_EN defined, only three loads occur and data_out stays 0.
- lock=1 with key 6 held -> no load. Separately, assert clear during PRESS_DB -> all outputs return to reset values immediately, asynchronously.
